// File: rtl/button_conditioner.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : button_conditioner                                            |
// | Description : Push-button synchroniser, debouncer and short/long press      |
// |               classifier with a direction toggle for the swipe stage.       |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module button_conditioner #(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int LONG_CYCLES     = 27000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic toggle
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int H_W  = $clog2(LONG_CYCLES);

    localparam logic [DB_W-1:0] c_DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [H_W-1:0]  c_LONG_LAST = H_W'(LONG_CYCLES - 1);
    localparam logic            c_INVERT    = (ACTIVE_LOW != 0);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_HELD = 2'd1;
    localparam logic [1:0] c_LONG = 2'd2;

    logic            w_raw_p;
    logic            r_sync1;
    logic            r_sync2;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_pressed;
    logic            r_press_pulse;
    logic            r_release_pulse;
    logic            w_commit;
    logic            w_press_commit;
    logic            w_release_commit;
    logic [1:0]      r_state;
    logic [H_W-1:0]  r_h_cnt;
    logic            r_short_pulse;
    logic            r_long_pulse;
    logic            r_toggle;

    assign w_raw_p          = btn ^ c_INVERT;
    assign w_commit         = (r_sync2 != r_pressed) && (r_db_cnt == c_DB_LAST);
    assign w_press_commit   = w_commit && r_sync2;
    assign w_release_commit = w_commit && !r_sync2;

    // Synchroniser resets to the released level so a held button is re-debounced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= w_raw_p;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt        <= '0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
        end else begin
            r_press_pulse   <= w_press_commit;
            r_release_pulse <= w_release_commit;
            if (r_sync2 == r_pressed || w_commit) begin
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
            if (w_commit) begin
                r_pressed <= r_sync2;
            end
        end
    end

    // A release commit takes priority over reaching the long threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_h_cnt       <= '0;
            r_short_pulse <= 1'b0;
            r_long_pulse  <= 1'b0;
            r_toggle      <= 1'b0;
        end else begin
            r_short_pulse <= 1'b0;
            r_long_pulse  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_press_commit) begin
                        r_state <= c_HELD;
                        r_h_cnt <= '0;
                    end
                end
                c_HELD: begin
                    if (w_release_commit) begin
                        r_state       <= c_IDLE;
                        r_short_pulse <= 1'b1;
                        r_toggle      <= ~r_toggle;
                    end else if (r_h_cnt == c_LONG_LAST) begin
                        r_state      <= c_LONG;
                        r_long_pulse <= 1'b1;
                    end else begin
                        r_h_cnt <= r_h_cnt + H_W'(1);
                    end
                end
                c_LONG: begin
                    if (w_release_commit) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign pressed       = r_pressed;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign short_pulse   = r_short_pulse;
    assign long_pulse    = r_long_pulse;
    assign toggle        = r_toggle;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_button_conditioner                                         |
// | Description : Directed self-checking bench for button_conditioner.          |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_button_conditioner;

    logic clk;
    logic rst_n;
    logic btn;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic short_pulse;
    logic long_pulse;
    logic toggle;

    int checks;
    int errors;

    button_conditioner #(
        .ACTIVE_LOW      (1),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn           (btn),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_pulse   (short_pulse),
        .long_pulse    (long_pulse),
        .toggle        (toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {pressed, press, release, short, long, toggle}
    function automatic logic [5:0] obs();
        return {pressed, press_pulse, release_pulse, short_pulse, long_pulse, toggle};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [5:0] exp);
        checks++;
        assert (obs() === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs(), exp);
        end
    endtask

    task automatic expect_for(input string tag, input int n, input logic [5:0] exp);
        for (int i = 0; i < n; i++) begin
            tick();
            check(tag, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        btn    = 1'b1;

        // Reset, then idle with button released
        #1;
        check("reset_async", 6'b000000);
        expect_for("reset_hold", 3, 6'b000000);
        rst_n = 1'b1;
        expect_for("idle", 50, 6'b000000);

        // Short press
        btn = 1'b0;
        expect_for("short_press_wait", 5, 6'b000000);
        tick(); check("short_press_pulse", 6'b110000);
        expect_for("short_held", 4, 6'b100000);
        btn = 1'b1;
        expect_for("short_release_wait", 5, 6'b100000);
        tick(); check("short_release_pulse", 6'b001101);
        expect_for("short_after", 3, 6'b000001);

        // Bounces never stable for 4 cycles
        btn = 1'b0; expect_for("glitch_low1", 3, 6'b000001);
        btn = 1'b1; expect_for("glitch_high", 2, 6'b000001);
        btn = 1'b0; expect_for("glitch_low2", 3, 6'b000001);
        btn = 1'b1; expect_for("glitch_settle", 10, 6'b000001);

        // Long press
        btn = 1'b0;
        expect_for("long_press_wait", 5, 6'b000001);
        tick(); check("long_press_pulse", 6'b110001);
        expect_for("long_hold", 19, 6'b100001);
        tick(); check("long_pulse", 6'b100011);
        expect_for("long_frozen", 14, 6'b100001);
        btn = 1'b1;
        expect_for("long_release_wait", 5, 6'b100001);
        tick(); check("long_release_pulse", 6'b001001);
        expect_for("long_after", 3, 6'b000001);

        // Release commit collides with long threshold: release wins
        btn = 1'b0;
        expect_for("race_press_wait", 5, 6'b000001);
        tick(); check("race_press_pulse", 6'b110001);
        expect_for("race_hold", 14, 6'b100001);
        btn = 1'b1;
        expect_for("race_release_wait", 5, 6'b100001);
        tick(); check("race_release_short", 6'b001100);
        expect_for("race_no_long", 25, 6'b000000);

        // Reset in the middle of a held press
        btn = 1'b0;
        expect_for("rst_press_wait", 5, 6'b000000);
        tick(); check("rst_press_pulse", 6'b110000);
        expect_for("rst_held", 4, 6'b100000);
        rst_n = 1'b0;
        #1;
        check("rst_mid_async", 6'b000000);
        expect_for("rst_mid_hold", 4, 6'b000000);
        rst_n = 1'b1;
        expect_for("rst_rel_wait", 5, 6'b000000);
        tick(); check("rst_rel_press_pulse", 6'b110000);
        expect_for("rst_rel_held", 5, 6'b100000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
